// File: rtl/alu_pkg.sv
// alu_pkg: mul/div op encodings and FSM state type.
// Shared by the decoder and alu_muldiv.
package alu_pkg;

  localparam int MD_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  function automatic logic md_is_signed(md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_arith(md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_step.sv
// md_step: one radix-2 iteration, shift-add multiply or restoring divide.
// Ports: mode_i (1=divide), acc_i/acc_o (2W+1 accumulator), opnd_i (W operand).
module md_step
  import alu_pkg::*;
#(
  parameter int W = MD_DATA_WIDTH
) (
  input  logic           mode_i,
  input  logic [2*W:0]   acc_i,
  input  logic [W-1:0]   opnd_i,
  output logic [2*W:0]   acc_o
);

  logic [W:0]   sum;
  logic [W:0]   rem;
  logic [W:0]   diff;
  logic [2*W:0] sh;

  always_comb begin
    sum   = {1'b0, acc_i[2*W-1:W]} + {1'b0, opnd_i};
    sh    = {acc_i[2*W-1:0], 1'b0};
    rem   = sh[2*W:W];
    diff  = rem - {1'b0, opnd_i};
    acc_o = '0;
    if (mode_i) begin
      // remainder lives in the upper W+1 bits, quotient shifts in at bit 0
      if (rem >= {1'b0, opnd_i}) begin
        acc_o = {diff, sh[W-1:1], 1'b1};
      end else begin
        acc_o = sh;
      end
    end else begin
      // multiplier is consumed from bit 0 as the product shifts in on top
      if (acc_i[0]) begin
        acc_o = {1'b0, sum, acc_i[W-1:1]};
      end else begin
        acc_o = {1'b0, acc_i[2*W:1]};
      end
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO.
// Ports: clk, rst_n (sync), start/op/a/b request, flush; busy, done, hi, lo.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  md_op_t                op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W = DATA_WIDTH;
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W - 1);

  md_state_t state_q, state_d;

  logic [2*W:0]         acc_q, acc_d, acc_step;
  logic [W-1:0]         opnd_q, opnd_d;
  logic [W-1:0]         hi_q, hi_d;
  logic [W-1:0]         lo_q, lo_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 div_q, div_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic                 dz_q, dz_d;
  logic                 done_q, done_d;

  logic                 a_neg, b_neg, op_div;
  logic [W-1:0]         a_abs, b_abs;
  logic [2*W-1:0]       prod;
  logic [W-1:0]         quo, rem;

  always_comb begin
    op_div = md_is_div(op);
    a_neg  = md_is_signed(op) & a[W-1];
    b_neg  = md_is_signed(op) & b[W-1];
    a_abs  = a_neg ? (~a + 1'b1) : a;
    b_abs  = b_neg ? (~b + 1'b1) : b;
  end

  md_step #(
    .W (W)
  ) u_step (
    .mode_i (div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  // sign correction: only two's-complement negation of unsigned results
  always_comb begin
    prod = neg_lo_q ? (~acc_q[2*W-1:0] + 1'b1) : acc_q[2*W-1:0];
    quo  = neg_lo_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
    rem  = neg_hi_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    if (flush) begin
      state_d = MD_IDLE;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (start) begin
            if (op == MD_MTHI) begin
              hi_d = a;
            end else if (op == MD_MTLO) begin
              lo_d = a;
            end else if (md_is_arith(op)) begin
              state_d  = MD_RUN;
              cnt_d    = '0;
              div_d    = op_div;
              acc_d    = {{(W+1){1'b0}}, op_div ? a_abs : b_abs};
              opnd_d   = op_div ? b_abs : a_abs;
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = op_div ? a_neg : (a_neg ^ b_neg);
              dz_d     = op_div && (b == '0);
            end
          end
        end
        MD_RUN: begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = MD_FIX;
          end
        end
        MD_FIX: begin
          state_d = MD_IDLE;
          done_d  = 1'b1;
          if (div_q) begin
            // divide by zero keeps remainder = dividend after correction
            hi_d = rem;
            lo_d = dz_q ? '1 : quo;
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
        default: begin
          state_d = MD_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != MD_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: scoreboard bench for alu_muldiv at DATA_WIDTH=32.
// Reference results come from plain 64-bit integer arithmetic.
module tb_alu_muldiv;
  import alu_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  md_op_t      op = MD_MULT;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;
  exp_t        sb[$];

  alu_muldiv #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_md(input md_op_t o,
                                         input logic [31:0] x,
                                         input logic [31:0] y,
                                         input logic [63:0] cur);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = cur;
    case (o)
      MD_MULT:  res = 64'(sx * sy);
      MD_MULTU: res = {32'd0, x} * {32'd0, y};
      MD_DIV: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          res = {32'd0, 32'h8000_0000};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      MD_DIVU: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else res = {x % y, x / y};
      end
      MD_MTHI: res = {x, cur[31:0]};
      MD_MTLO: res = {cur[63:32], x};
      default: res = cur;
    endcase
    return res;
  endfunction

  function automatic bit is_md(input md_op_t o);
    return o inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

  // monitor: every done pulse must match the oldest outstanding result
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: hi=%h lo=%h, no result pending", hi, lo);
      end else begin
        e = sb.pop_front();
        chk("mon_hi", 64'(hi), 64'(e.hi));
        chk("mon_lo", 64'(lo), 64'(e.lo));
        chk("mon_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // drives a request, returns after the accept edge with start still high
  task automatic issue(input md_op_t o, input logic [31:0] x,
                       input logic [31:0] y, input bit push,
                       input logic [63:0] r, output int acc);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) sb.push_back('{r[63:32], r[31:0], acc + LAT});
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic run_op(input md_op_t o, input logic [31:0] x,
                        input logic [31:0] y);
    int acc, n;
    logic [63:0] r;
    r = ref_md(o, x, y, {mdl_hi, mdl_lo});
    issue(o, x, y, is_md(o), r, acc);
    @(negedge clk);
    start = 1'b0;
    if (is_md(o)) begin
      wait_idle(n);
      chk("busy_len", 64'(n), 64'(LAT));
      chk("final_hilo", {hi, lo}, r);
    end else begin
      chk("mtx_hilo", {hi, lo}, r);
      chk("mtx_busy", 64'(busy), 64'd0);
      chk("mtx_done", 64'(done), 64'd0);
    end
    {mdl_hi, mdl_lo} = r;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, n;
    logic [63:0] r;
    exp_t dmy;
    logic [31:0] edges [5];
    md_op_t ro;
    logic [31:0] ra, rb;

    edges[0] = 32'h0000_0000;
    edges[1] = 32'h0000_0001;
    edges[2] = 32'hFFFF_FFFF;
    edges[3] = 32'h8000_0000;
    edges[4] = 32'h7FFF_FFFF;

    repeat (3) @(negedge clk);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(MD_MTHI, 32'h1234_5678, 32'd0);
    run_op(MD_MTLO, 32'hCAFE_0001, 32'd0);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op(MD_DIVU, 32'd7, 32'd0);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd0);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE);

    // flush mid-op; a MULT issued while busy must be ignored
    r = ref_md(MD_DIVU, 32'd100, 32'd7, {mdl_hi, mdl_lo});
    issue(MD_DIVU, 32'd100, 32'd7, 1'b1, r, acc);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    op = MD_MULT;
    a = 32'd5;
    b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + 9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    dmy = sb.pop_back();
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    repeat (40) @(negedge clk);
    chk("flush_hilo", {hi, lo}, {mdl_hi, mdl_lo});
    run_op(MD_DIVU, 32'd100, 32'd7);

    // flush in idle suppresses a same-cycle MTHI and MULT
    start = 1'b1;
    op = MD_MTHI;
    a = 32'hDEAD_BEEF;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_mthi", 64'(hi), 64'(mdl_hi));
    op = MD_MULT;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("flush_idle_mult", 64'(busy), 64'd0);
    @(negedge clk);

    // synchronous reset in the middle of a MULT
    r = ref_md(MD_MULT, 32'd123, 32'd456, {mdl_hi, mdl_lo});
    issue(MD_MULT, 32'd123, 32'd456, 1'b1, r, acc);
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + 4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    mdl_hi = '0;
    mdl_lo = '0;
    chk("midrst_hilo", {hi, lo}, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(MD_MULT, 32'd123, 32'd456);

    // back-to-back: second op accepted in the done cycle
    r = ref_md(MD_MULTU, 32'd3, 32'd5, {mdl_hi, mdl_lo});
    issue(MD_MULTU, 32'd3, 32'd5, 1'b1, r, acc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    chk("b2b_first_done", 64'(done), 64'd1);
    {mdl_hi, mdl_lo} = r;
    r = ref_md(MD_DIVU, 32'd9, 32'd2, {mdl_hi, mdl_lo});
    op = MD_DIVU;
    a = 32'd9;
    b = 32'd2;
    @(posedge clk);
    #1;
    acc2 = cyc;
    chk("b2b_gap", 64'(acc2 - acc), 64'(LAT + 1));
    sb.push_back('{r[63:32], r[31:0], acc2 + LAT});
    @(negedge clk);
    start = 1'b0;
    wait_idle(n);
    chk("b2b_busy_len", 64'(n), 64'(LAT));
    chk("b2b_hilo", {hi, lo}, r);
    {mdl_hi, mdl_lo} = r;

    // randomized ops with a bias toward boundary operands
    for (int i = 0; i < 40; i++) begin
      ro = md_op_t'($urandom_range(0, 5));
      ra = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_000F;
      run_op(ro, ra, rb);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
